sine_channel_scheduler: RTL
===========================

# sine_channel_scheduler

Time-multiplexes one shared sine generator datapath (12-bit phase in, 10-bit phase offset in, 12-bit unsigned sine out, fixed pipeline latency) across NUM_CH independent output channels. Holds per-channel phase accumulators, tuning words, phase offsets and enables, written through a valid/ready config port. On each sample tick it issues one phase per channel to the generator and captures the returned samples into per-channel output registers. It sits between the sample-rate timebase and the DAC/channel output stage.

## Interface
- NUM_CH, 4: channel count; power of 2, 2..16
- ACC_W, 32: phase accumulator width; ACC_W ≥ 12
- GEN_LAT, 3: generator latency in cycles, from phase presented to matching gen_sine valid; ≥ 1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sample_tick  in  1  one-cycle pulse that requests one round (one sample per channel)
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
- cfg_ch  in  log2(NUM_CH)  channel to write
- cfg_tuning  in  ACC_W  tuning word
- cfg_offset  in  10  phase offset, 0-999
- cfg_enable  in  1  channel enable
- gen_phase  out  12  phase to generator
- gen_offset  out  10  phase offset to generator
- gen_sine  in  12  generator output
- ch_sample  out  NUM_CH*12  per-channel sample; channel k in bits [12k+11:12k]
- ch_valid  out  NUM_CH  one-cycle pulse per channel update
- round_done  out  1  one-cycle pulse, round complete
- overrun  out  1  sticky flag, tick arrived while busy

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE + sample_tick → ISSUE, with ch_idx = 0.
  - ISSUE: one channel per cycle, ch_idx 0..NUM_CH-1. After the last channel → DRAIN.
  - DRAIN: wait until the last tag leaves the delay line, then → IDLE.
- Issue of channel k (registered outputs):
  - gen_phase = acc[k][ACC_W-1 -: 12], value before increment.
  - gen_offset = offset[k].
  - Same edge: acc[k] <= acc[k] + tuning[k] if enable[k], wrapping modulo 2^ACC_W; else acc[k] <= 0.
- Tag {valid, ch, enable} enters a GEN_LAT-deep delay line aligned to gen_phase. When a tag emerges valid:
  - ch_sample[ch] <= enable ? gen_sine : 12'd2048.
  - ch_valid[ch] pulses.
- round_done pulses in the same cycle as the ch_valid of channel NUM_CH-1.
- Outside ISSUE, gen_phase and gen_offset hold their last values.
- Config port:
  - cfg_ready = rst_n & (state == IDLE).
  - On handshake, write tuning, offset and enable of cfg_ch; the accumulator is untouched.
  - cfg and sample_tick in the same IDLE cycle: both take effect, and the round uses the new config.
- sample_tick outside IDLE is ignored and sets overrun. Only reset clears overrun.
- Reset mid-round: FSM → IDLE, delay line cleared. No ch_valid or round_done follows, and late gen_sine is ignored.
- Reset values:
  - acc, tuning, offset, enable: 0.
  - ch_sample: all 12'd2048. gen_phase and gen_offset: 0.
  - ch_valid, round_done, overrun: 0. cfg_ready: 0 while rst_n is low.

## Timing
- Tick accepted in cycle t → channel k presented on gen_phase in cycle t+1+k.
- ch_valid[k] and ch_sample[k] updated, visible in cycle t+2+k+GEN_LAT.
- round_done in cycle t+1+NUM_CH+GEN_LAT.
- DRAIN ends so that cfg_ready returns in the cycle after round_done.
- Minimum tick spacing is NUM_CH+GEN_LAT+2 cycles. A tick arriving in the round_done cycle is an overrun.
- Round throughput: 1 channel per cycle, no bubbles in ISSUE.

## Structure
- Package sine_sched_pkg holds:
  - the state enum {IDLE, ISSUE, DRAIN};
  - MIDSCALE = 12'd2048;
  - SAMPLE_W = 12, OFFSET_W = 10.
- Sub-module sine_sched_tagpipe: parameterised GEN_LAT-deep shift register with synchronous clear, carrying {valid, ch, enable}.
- Per-channel state lives in register arrays in the top module. The generator itself is instantiated outside this block.

## Test plan
- Bench setup: NUM_CH=4, GEN_LAT=3. gen_sine is driven by a delay model returning {gen_phase} delayed 3 cycles, so captures are traceable.
- Reset and idle: after reset, ch_sample all 0x800, cfg_ready=1, ch_valid=0. A tick with all channels disabled → four ch_valid pulses, all samples 0x800, round_done at t+8.
- Accumulator step: ch0 enabled with tuning 0x0010_0000 → round n presents gen_phase=n on ch0 and ch_sample[0]=n. With tuning 0xFFF0_0000, the second round wraps to gen_phase=0xFFF, then the third round gives 0xFFE.
- Config/tick collision: cfg_valid (ch2, offset 500, enable) in the same IDLE cycle as sample_tick → this round presents gen_offset=500 for ch2 in cycle t+3.
- Overrun: a second tick at t+4 → ignored, overrun=1 and stays set; the round completes normally; cfg_ready=0 from t+1 until the cycle after round_done.
- Reset mid-round: rst_n low at t+5 for one cycle → no further ch_valid or round_done, acc cleared, and a tick after reset runs a clean round.

Source files
------------

// File: rtl/sine_sched_pkg.sv
// Shared types and constants for the sine channel scheduler.
//   state_e  : round sequencing states
//   MIDSCALE : sample value reported for a disabled channel (unsigned zero level)
//   SAMPLE_W : generator sample width
//   OFFSET_W : phase offset width
package sine_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SAMPLE_W = 12;
  localparam int OFFSET_W = 10;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'd2048;

endpackage

// File: rtl/sine_sched_tagpipe.sv
// Tag delay line matching the shared generator latency. A tag entering in
// cycle c leaves GEN_LAT cycles later, alongside the generator's sample.
//   clk         : clock
//   clr_i       : synchronous clear (empties the line)
//   tag_valid_i : tag present
//   tag_ch_i    : channel the tag belongs to
//   tag_en_i    : channel enable at issue time
//   tag_valid_o / tag_ch_o / tag_en_o : tag leaving the line
module sine_sched_tagpipe #(
  parameter int GEN_LAT = 3,
  parameter int CH_W    = 2
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic            tag_valid_i,
  input  logic [CH_W-1:0] tag_ch_i,
  input  logic            tag_en_i,
  output logic            tag_valid_o,
  output logic [CH_W-1:0] tag_ch_o,
  output logic            tag_en_o
);

  logic [GEN_LAT-1:0] valid_q;
  logic [GEN_LAT-1:0] en_q;
  logic [CH_W-1:0]    ch_q [GEN_LAT];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
      en_q    <= '0;
      for (int i = 0; i < GEN_LAT; i++) ch_q[i] <= '0;
    end else begin
      valid_q[0] <= tag_valid_i;
      en_q[0]    <= tag_en_i;
      ch_q[0]    <= tag_ch_i;
      for (int i = 1; i < GEN_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        en_q[i]    <= en_q[i-1];
        ch_q[i]    <= ch_q[i-1];
      end
    end
  end

  assign tag_valid_o = valid_q[GEN_LAT-1];
  assign tag_en_o    = en_q[GEN_LAT-1];
  assign tag_ch_o    = ch_q[GEN_LAT-1];

endmodule

// File: rtl/sine_channel_scheduler.sv
// Time-multiplexes one shared sine generator across NUM_CH channels.
// Holds per-channel accumulators/config, issues one phase per channel per
// sample tick, and captures the returned samples per channel.
//   clk, rst_n                : clock, synchronous active-low reset
//   sample_tick               : request one round
//   cfg_valid/ready, cfg_*    : per-channel config write port
//   gen_phase, gen_offset     : to the generator (registered)
//   gen_sine                  : from the generator, GEN_LAT after gen_phase
//   ch_sample, ch_valid       : per-channel captured samples and update pulses
//   round_done                : pulse with the last channel's update
//   overrun                   : sticky, tick seen while a round was running
//
// state | meaning
// IDLE  | waiting for sample_tick, config port open
// ISSUE | presenting channel ch_idx_q on gen_phase
// DRAIN | waiting for the last tag to leave the delay line
module sine_channel_scheduler
  import sine_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ACC_W   = 32,
  parameter int GEN_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_tick,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
  input  logic [ACC_W-1:0]             cfg_tuning,
  input  logic [OFFSET_W-1:0]          cfg_offset,
  input  logic                         cfg_enable,
  output logic [SAMPLE_W-1:0]          gen_phase,
  output logic [OFFSET_W-1:0]          gen_offset,
  input  logic [SAMPLE_W-1:0]          gen_sine,
  output logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
  output logic [NUM_CH-1:0]            ch_valid,
  output logic                         round_done,
  output logic                         overrun
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e                state_q;
  logic [CH_W-1:0]       ch_idx_q;
  logic [ACC_W-1:0]      acc_q     [NUM_CH];
  logic [ACC_W-1:0]      tuning_q  [NUM_CH];
  logic [OFFSET_W-1:0]   offset_q  [NUM_CH];
  logic [NUM_CH-1:0]     enable_q;
  logic [SAMPLE_W-1:0]   sample_q  [NUM_CH];
  logic [SAMPLE_W-1:0]   gen_phase_q;
  logic [OFFSET_W-1:0]   gen_offset_q;
  logic [NUM_CH-1:0]     ch_valid_q;
  logic                  round_done_q;
  logic                  overrun_q;
  logic                  tag_valid_q;
  logic [CH_W-1:0]       tag_ch_q;
  logic                  tag_en_q;

  logic                  cfg_fire;
  logic                  issue_en;
  logic [CH_W-1:0]       issue_ch;
  logic                  cfg_hit;
  logic [ACC_W-1:0]      tuning_eff;
  logic [OFFSET_W-1:0]   offset_eff;
  logic                  enable_eff;
  logic [ACC_W-1:0]      acc_d;
  logic                  pipe_valid;
  logic [CH_W-1:0]       pipe_ch;
  logic                  pipe_en;

  assign cfg_ready = rst_n & (state_q == IDLE);
  assign cfg_fire  = cfg_valid & cfg_ready;

  // Channel k is registered onto gen_phase at the edge before its ISSUE
  // cycle, so channel 0 issues on the tick edge itself.
  always_comb begin
    issue_en = 1'b0;
    issue_ch = '0;
    case (state_q)
      IDLE:    issue_en = sample_tick;
      ISSUE: begin
        issue_en = (ch_idx_q != LAST_CH);
        issue_ch = ch_idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // A config write landing with the tick must already steer this round.
  always_comb begin
    cfg_hit    = cfg_fire && (cfg_ch == issue_ch);
    tuning_eff = cfg_hit ? cfg_tuning : tuning_q[issue_ch];
    offset_eff = cfg_hit ? cfg_offset : offset_q[issue_ch];
    enable_eff = cfg_hit ? cfg_enable : enable_q[issue_ch];
    acc_d      = enable_eff ? acc_q[issue_ch] + tuning_eff : '0;
  end

  sine_sched_tagpipe #(
    .GEN_LAT (GEN_LAT),
    .CH_W    (CH_W)
  ) u_tagpipe (
    .clk         (clk),
    .clr_i       (~rst_n),
    .tag_valid_i (tag_valid_q),
    .tag_ch_i    (tag_ch_q),
    .tag_en_i    (tag_en_q),
    .tag_valid_o (pipe_valid),
    .tag_ch_o    (pipe_ch),
    .tag_en_o    (pipe_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_idx_q     <= '0;
      enable_q     <= '0;
      gen_phase_q  <= '0;
      gen_offset_q <= '0;
      ch_valid_q   <= '0;
      round_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      tag_valid_q  <= 1'b0;
      tag_ch_q     <= '0;
      tag_en_q     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_q[k]    <= '0;
        tuning_q[k] <= '0;
        offset_q[k] <= '0;
        sample_q[k] <= MIDSCALE;
      end
    end else begin
      ch_valid_q   <= '0;
      round_done_q <= 1'b0;

      if (cfg_fire) begin
        tuning_q[cfg_ch] <= cfg_tuning;
        offset_q[cfg_ch] <= cfg_offset;
        enable_q[cfg_ch] <= cfg_enable;
      end

      if (issue_en) begin
        gen_phase_q     <= acc_q[issue_ch][ACC_W-1 -: SAMPLE_W];
        gen_offset_q    <= offset_eff;
        acc_q[issue_ch] <= acc_d;
      end
      tag_valid_q <= issue_en;
      tag_ch_q    <= issue_ch;
      tag_en_q    <= enable_eff;

      if (pipe_valid) begin
        sample_q[pipe_ch]   <= pipe_en ? gen_sine : MIDSCALE;
        ch_valid_q[pipe_ch] <= 1'b1;
        round_done_q        <= (pipe_ch == LAST_CH);
      end

      if (sample_tick && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: if (sample_tick) begin
          state_q  <= ISSUE;
          ch_idx_q <= '0;
        end
        ISSUE: begin
          if (ch_idx_q == LAST_CH) state_q <= DRAIN;
          else                     ch_idx_q <= ch_idx_q + 1'b1;
        end
        // round_done_q marks the final capture; leave on the following edge.
        DRAIN: if (round_done_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gen_phase  = gen_phase_q;
  assign gen_offset = gen_offset_q;
  assign ch_valid   = ch_valid_q;
  assign round_done = round_done_q;
  assign overrun    = overrun_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign ch_sample[k*SAMPLE_W +: SAMPLE_W] = sample_q[k];
  end

endmodule
